// File: rtl/alu_muldiv.sv
// Single-issue ALU with a valid/ready handshake and an optional iterative multiply/divide unit.
// Define ALU_MULDIV_EN to build ops 0x10-0x17; otherwise they decode as undefined ops.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic [3:0]      flags_reg, flags_next;

  logic [XLEN:0]   add_full, sub_full;
  logic            add_v, sub_v, slt_lt;
  logic [XLEN-1:0] base_res;
  logic            base_n, base_c, base_v;
  logic [3:0]      base_flags;

  assign add_full = {1'b0, src_a} + {1'b0, src_b};
  // Subtract as a + ~b + 1 so the carry out is directly NOT borrow.
  assign sub_full = {1'b0, src_a} + {1'b0, ~src_b} + {{XLEN{1'b0}}, 1'b1};
  assign add_v    = (src_a[XLEN-1] == src_b[XLEN-1]) && (add_full[XLEN-1] != src_a[XLEN-1]);
  assign sub_v    = (src_a[XLEN-1] != src_b[XLEN-1]) && (sub_full[XLEN-1] != src_a[XLEN-1]);
  assign slt_lt   = $signed(src_a) < $signed(src_b);

  always_comb begin
    base_res = '0;
    base_n   = 1'b0;
    base_c   = 1'b0;
    base_v   = 1'b0;
    case (op)
      5'h00: begin base_res = add_full[XLEN-1:0]; base_n = add_full[XLEN-1]; base_c = add_full[XLEN]; base_v = add_v; end
      5'h01: begin base_res = sub_full[XLEN-1:0]; base_n = sub_full[XLEN-1]; base_c = sub_full[XLEN]; base_v = sub_v; end
      5'h02: base_res = src_a & src_b;
      5'h03: base_res = src_a | src_b;
      5'h04: begin base_res = {{(XLEN-1){1'b0}}, slt_lt}; base_n = base_res[XLEN-1]; base_v = sub_v; end
      5'h05: base_res = src_a << src_b[SHW-1:0];
      5'h06: base_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      5'h07: base_res = src_a ^ src_b;
      5'h08: base_res = src_a >> src_b[SHW-1:0];
      5'h09: begin base_res = $signed(src_a) >>> src_b[SHW-1:0]; base_n = base_res[XLEN-1]; end
      default: base_res = '0;
    endcase
    base_flags = {base_n, (base_res == '0), base_c, base_v};
  end

`ifdef ALU_MULDIV_EN
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  logic [2*XLEN-1:0] acc_reg, acc_next, init_acc, step_acc, mul_acc, div_acc, prod_s;
  logic [XLEN-1:0]   opnd_reg, opnd_next, init_opnd, a_mag, b_mag, quick_res, fin_res;
  logic [SHW-1:0]    cnt_reg, cnt_next;
  logic [2:0]        mop_reg, mop_next;
  logic              neg_reg, neg_next, neg_rem_reg, neg_rem_next;
  logic              init_neg, init_neg_rem, md_op, div_zero, div_ovf;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  function automatic logic [3:0] md_flags(input logic [XLEN-1:0] r);
    return {r[XLEN-1], (r == '0), 2'b00};
  endfunction

  assign md_op = (op[4:3] == 2'b10);

  // Operands are reduced to magnitudes; the sign is restored once on the final cycle.
  always_comb begin
    a_mag        = src_a;
    b_mag        = src_b;
    init_neg     = 1'b0;
    init_neg_rem = 1'b0;
    case (op[2:0])
      3'd1: begin a_mag = mag(src_a); b_mag = mag(src_b); init_neg = src_a[XLEN-1] ^ src_b[XLEN-1]; end
      3'd2: begin a_mag = mag(src_a); init_neg = src_a[XLEN-1]; end
      3'd4, 3'd6: begin
        a_mag        = mag(src_a);
        b_mag        = mag(src_b);
        init_neg     = src_a[XLEN-1] ^ src_b[XLEN-1];
        init_neg_rem = src_a[XLEN-1];
      end
      default: a_mag = src_a;
    endcase
    if (op[2]) begin
      init_acc  = {{XLEN{1'b0}}, a_mag};
      init_opnd = b_mag;
    end else begin
      init_acc  = {{XLEN{1'b0}}, b_mag};
      init_opnd = a_mag;
    end
    div_zero  = op[2] && (src_b == '0);
    div_ovf   = op[2] && !op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    quick_res = '0;
    if (div_zero)     quick_res = op[1] ? src_a : '1;
    else if (div_ovf) quick_res = op[1] ? '0 : src_a;
  end

  // One shift-add (multiply) or restoring-subtract (divide) step per cycle.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_acc   = {mul_sum, acc_reg[XLEN-1:1]};
    div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    div_acc   = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    step_acc  = mop_reg[2] ? div_acc : mul_acc;
    prod_s    = neg_reg ? -step_acc : step_acc;
    if (mop_reg[2]) begin
      if (mop_reg[1]) fin_res = neg_rem_reg ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
      else            fin_res = neg_reg ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    end else begin
      fin_res = (mop_reg[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end
`endif

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
`ifdef ALU_MULDIV_EN
    acc_next     = acc_reg;
    opnd_next    = opnd_reg;
    cnt_next     = cnt_reg;
    mop_next     = mop_reg;
    neg_next     = neg_reg;
    neg_rem_next = neg_rem_reg;
`endif
    case (state_reg)
      IDLE: if (in_valid) begin
`ifdef ALU_MULDIV_EN
        if (md_op) begin
          mop_next = op[2:0];
          if (div_zero || div_ovf) begin
            result_next = quick_res;
            flags_next  = md_flags(quick_res);
            state_next  = DONE;
          end else begin
            acc_next     = init_acc;
            opnd_next    = init_opnd;
            neg_next     = init_neg;
            neg_rem_next = init_neg_rem;
            cnt_next     = '0;
            state_next   = BUSY;
          end
        end else
`endif
        begin
          result_next = base_res;
          flags_next  = base_flags;
          state_next  = DONE;
        end
      end
      BUSY: if (kill) begin
        state_next = IDLE;
      end else begin
`ifdef ALU_MULDIV_EN
        acc_next = step_acc;
        cnt_next = cnt_reg + SHW'(1);
        if (cnt_reg == LAST) begin
          result_next = fin_res;
          flags_next  = md_flags(fin_res);
          state_next  = DONE;
        end
`else
        state_next = IDLE;
`endif
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      flags_reg  <= '0;
`ifdef ALU_MULDIV_EN
      acc_reg     <= '0;
      opnd_reg    <= '0;
      cnt_reg     <= '0;
      mop_reg     <= '0;
      neg_reg     <= 1'b0;
      neg_rem_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
`ifdef ALU_MULDIV_EN
      acc_reg     <= acc_next;
      opnd_reg    <= opnd_next;
      cnt_reg     <= cnt_next;
      mop_reg     <= mop_next;
      neg_reg     <= neg_next;
      neg_rem_reg <= neg_rem_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign flags     = flags_reg;
`ifdef ALU_MULDIV_EN
  assign busy = (state_reg == BUSY);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at XLEN=32.
// Multiply/divide scenarios run when ALU_MULDIV_EN is defined; otherwise those ops are checked as undefined.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst, in_valid, kill, out_ready;
  logic [4:0]  op;
  logic [31:0] src_a, src_b;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic [3:0]  flags;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    logic [7:0]  lat;
  } vec_t;

  vec_t base_vecs [15] = '{
    '{5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 8'd1},
    '{5'h01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 8'd1},
    '{5'h02, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 8'd1},
    '{5'h03, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100, 8'd1},
    '{5'h04, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 8'd1},
    '{5'h04, 32'h80000000, 32'h00000001, 32'h00000001, 4'b0001, 8'd1},
    '{5'h05, 32'h00000001, 32'h0000003F, 32'h80000000, 4'b0000, 8'd1},
    '{5'h06, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 8'd1},
    '{5'h07, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b0100, 8'd1},
    '{5'h08, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 8'd1},
    '{5'h09, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000, 8'd1},
    '{5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 8'd1},
    '{5'h01, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 8'd1},
    '{5'h01, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 8'd1},
    '{5'h1F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0100, 8'd1}
  };

`ifdef ALU_MULDIV_EN
  vec_t md_vecs [13] = '{
    '{5'h11, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 8'd33},
    '{5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1000, 8'd1},
    '{5'h15, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 8'd1},
    '{5'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b1000, 8'd33},
    '{5'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b1000, 8'd33},
    '{5'h10, 32'h00000006, 32'h00000007, 32'h0000002A, 4'b0000, 8'd33},
    '{5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 8'd33},
    '{5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 8'd33},
    '{5'h15, 32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000, 8'd33},
    '{5'h17, 32'h00000064, 32'h00000007, 32'h00000002, 4'b0000, 8'd33},
    '{5'h16, 32'h00000005, 32'h00000000, 32'h00000005, 4'b0000, 8'd1},
    '{5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 8'd1},
    '{5'h11, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b1000, 8'd33}
  };
`endif

  alu_muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one edge, then scramble the inputs so later cycles cannot leak in.
  task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op = 5'h02; src_a = 32'hDEADBEEF; src_b = 32'h12345678;
  endtask

  // Returns cycles since accept at which out_valid was seen, and busy-cycle count; bounded.
  task automatic wait_valid(output int n, output int busy_n);
    n = 1; busy_n = 0;
    while (!out_valid && n < 200) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result got=%h want=0", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'h0) $display("FAIL reset_flags got=%b want=0000", flags); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else pass_cnt++;
    $display("reset: out_valid=%b busy=%b result=%h flags=%b in_ready=%b", out_valid, busy, result, flags, in_ready);
  endtask

  task automatic test_base();
    for (int i = 0; i < 15; i++) begin
      send(base_vecs[i].op, base_vecs[i].a, base_vecs[i].b);
      $display("base op=%h a=%h b=%h -> valid=%b result=%h flags=%b", base_vecs[i].op,
               base_vecs[i].a, base_vecs[i].b, out_valid, result, flags);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL base_valid[%0d] got=%b want=1", i, out_valid); else pass_cnt++;
      total_cnt++; if (result !== base_vecs[i].res) $display("FAIL base_result[%0d] got=%h want=%h", i, result, base_vecs[i].res); else pass_cnt++;
      total_cnt++; if (flags !== base_vecs[i].fl) $display("FAIL base_flags[%0d] got=%b want=%b", i, flags, base_vecs[i].fl); else pass_cnt++;
      drain();
    end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv();
    int n, bn;
    for (int i = 0; i < 13; i++) begin
      send(md_vecs[i].op, md_vecs[i].a, md_vecs[i].b);
      wait_valid(n, bn);
      $display("muldiv op=%h a=%h b=%h -> latency=%0d busy=%0d result=%h flags=%b", md_vecs[i].op,
               md_vecs[i].a, md_vecs[i].b, n, bn, result, flags);
      total_cnt++; if (n !== int'(md_vecs[i].lat)) $display("FAIL md_latency[%0d] got=%0d want=%0d", i, n, md_vecs[i].lat); else pass_cnt++;
      total_cnt++; if (bn !== int'(md_vecs[i].lat) - 1) $display("FAIL md_busy_cycles[%0d] got=%0d want=%0d", i, bn, md_vecs[i].lat - 8'd1); else pass_cnt++;
      total_cnt++; if (result !== md_vecs[i].res) $display("FAIL md_result[%0d] got=%h want=%h", i, result, md_vecs[i].res); else pass_cnt++;
      total_cnt++; if (flags !== md_vecs[i].fl) $display("FAIL md_flags[%0d] got=%b want=%b", i, flags, md_vecs[i].fl); else pass_cnt++;
      drain();
    end
  endtask

  task automatic test_kill();
    int seen = 0;
    send(5'h15, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL kill_busy_before got=%b want=1", busy); else pass_cnt++;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL kill_idle got in_ready=%b want=1", in_ready); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total_cnt++; if (seen !== 0) $display("FAIL kill_no_valid got=%0d valid cycles want=0", seen); else pass_cnt++;
    $display("kill: divu aborted, valid cycles after kill=%0d", seen);
  endtask
`else
  task automatic test_md_undefined();
    for (int i = 16; i < 24; i++) begin
      send(5'(i), 32'h00000007, 32'h00000003);
      $display("undef md op=%h -> valid=%b busy=%b result=%h flags=%b", i, out_valid, busy, result, flags);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL md_undef_valid[%0d] got=%b want=1", i, out_valid); else pass_cnt++;
      total_cnt++; if (result !== 32'h0) $display("FAIL md_undef_result[%0d] got=%h want=0", i, result); else pass_cnt++;
      total_cnt++; if (flags !== 4'b0100) $display("FAIL md_undef_flags[%0d] got=%b want=0100", i, flags); else pass_cnt++;
      drain();
      total_cnt++; if (busy !== 1'b0) $display("FAIL md_undef_busy[%0d] got=%b want=0", i, busy); else pass_cnt++;
    end
  endtask
`endif

  task automatic test_after_kill_add();
    send(5'h00, 32'd2, 32'd3);
    $display("add 2+3 -> valid=%b result=%h flags=%b", out_valid, result, flags);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL add23_valid got=%b want=1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd5) $display("FAIL add23_result got=%h want=5", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_midop();
`ifdef ALU_MULDIV_EN
    send(5'h10, 32'd9, 32'd9);
    tick(); tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got=%b want=1", busy); else pass_cnt++;
`else
    send(5'h00, 32'd9, 32'd9);
    total_cnt++; if (result !== 32'd18) $display("FAIL rstmid_result_before got=%h want=12", result); else pass_cnt++;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset mid-op: out_valid=%b busy=%b result=%h flags=%b in_ready=%b", out_valid, busy, result, flags, in_ready);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL rstmid_result got=%h want=0", result); else pass_cnt++;
    total_cnt++; if (flags !== 4'h0) $display("FAIL rstmid_flags got=%b want=0000", flags); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got=%b want=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_hold();
    int n, bn, bad = 0;
`ifdef ALU_MULDIV_EN
    send(5'h10, 32'hFFFFFFFF, 32'h00000002);
`else
    send(5'h01, 32'h00000003, 32'h00000005);
`endif
    wait_valid(n, bn);
    in_valid = 1'b1; op = 5'h00; src_a = 32'h1; src_b = 32'h1; kill = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || result !== 32'hFFFFFFFE || flags !== 4'b1000 || in_ready !== 1'b0) bad++;
      tick();
    end
    in_valid = 1'b0; kill = 1'b0;
    $display("hold: 5 cycles out_ready low, unstable cycles=%0d result=%h flags=%b", bad, result, flags);
    total_cnt++; if (bad !== 0) $display("FAIL hold_stable got=%0d bad cycles want=0", bad); else pass_cnt++;
    total_cnt++; if (result !== 32'hFFFFFFFE) $display("FAIL hold_result got=%h want=fffffffe", result); else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    send(5'h00, 32'd10, 32'd20);
    // Release and new request in the same DONE cycle: the request must not be taken.
    out_ready = 1'b1; in_valid = 1'b1; op = 5'h00; src_a = 32'd1; src_b = 32'd1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_in_done got=%b want=0", in_ready); else pass_cnt++;
    tick();
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_no_accept got out_valid=%b want=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_idle got in_ready=%b want=1", in_ready); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    $display("back-to-back: second add -> valid=%b result=%h", out_valid, result);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_second_valid got=%b want=1", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd2) $display("FAIL b2b_second_result got=%h want=2", result); else pass_cnt++;
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op = 5'h0; src_a = '0; src_b = '0;
    test_reset();
    test_base();
`ifdef ALU_MULDIV_EN
    test_muldiv();
    test_kill();
`else
    test_md_undefined();
`endif
    test_after_kill_add();
    test_reset_midop();
    test_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
